// File: rtl/clock_timebase.sv
// clock_timebase: divides clk down to a 1 s tick, keeps the seconds and
// minutes counters, and generates the enable/reset/load strobes for the
// downstream 1-12 hour counter, including a req/ack time-set handshake.
module clock_timebase #(
  parameter int CLKS_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_req,
  input  logic [3:0] set_hour,
  input  logic [5:0] set_min,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       sec_tick,
  output logic       hr_enable,
  output logic       hr_reset,
  output logic       hr_load,
  output logic [3:0] hr_d,
  output logic       set_ack,
  output logic       set_err
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLKS_PER_SEC - 1);

  typedef enum logic [1:0] {INIT, COUNT, ACK} state_t;

  state_t        state, state_next;
  logic [PW-1:0] ps, ps_next;
  logic [5:0]    sec_next, min_next;
  logic [3:0]    hr_d_next;
  logic          tick_next, en_next, rst_next, load_next;
  logic          ack_next, err_next;
  logic          set_valid;

  // Validity is judged on the full input width, so 13..15 hours and
  // 60..63 minutes are all rejected.
  assign set_valid = (set_hour >= 4'd1) && (set_hour <= 4'd12) &&
                     (set_min <= 6'd59);

  // Next-state and next-output logic; strobes default low so every pulse
  // lasts exactly one cycle.
  always_comb begin
    state_next = state;
    ps_next    = ps;
    sec_next   = sec;
    min_next   = min;
    hr_d_next  = hr_d;
    tick_next  = 1'b0;
    en_next    = 1'b0;
    rst_next   = 1'b0;
    load_next  = 1'b0;
    ack_next   = set_ack;
    err_next   = set_err;
    case (state)
      INIT: begin
        en_next    = 1'b1;
        rst_next   = 1'b1;
        state_next = COUNT;
      end
      COUNT: begin
        if (set_req) begin
          // A set takes priority over any tick or hour advance on this edge.
          ack_next   = 1'b1;
          state_next = ACK;
          if (set_valid) begin
            min_next  = set_min;
            sec_next  = 6'd0;
            ps_next   = '0;
            en_next   = 1'b1;
            load_next = 1'b1;
            hr_d_next = set_hour;
            err_next  = 1'b0;
          end else begin
            err_next  = 1'b1;
          end
        end else if (run) begin
          if (ps == PS_LAST) begin
            ps_next   = '0;
            tick_next = 1'b1;
            if (sec == 6'd59) begin
              sec_next = 6'd0;
              if (min == 6'd59) begin
                min_next = 6'd0;
                en_next  = 1'b1;
              end else begin
                min_next = min + 6'd1;
              end
            end else begin
              sec_next = sec + 6'd1;
            end
          end else begin
            ps_next = ps + PW'(1);
          end
        end
      end
      ACK: begin
        if (!set_req) begin
          ack_next   = 1'b0;
          err_next   = 1'b0;
          state_next = COUNT;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // State register and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      ps        <= '0;
      sec       <= 6'd0;
      min       <= 6'd0;
      sec_tick  <= 1'b0;
      hr_enable <= 1'b0;
      hr_reset  <= 1'b0;
      hr_load   <= 1'b0;
      hr_d      <= 4'd0;
      set_ack   <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      state     <= state_next;
      ps        <= ps_next;
      sec       <= sec_next;
      min       <= min_next;
      sec_tick  <= tick_next;
      hr_enable <= en_next;
      hr_reset  <= rst_next;
      hr_load   <= load_next;
      hr_d      <= hr_d_next;
      set_ack   <= ack_next;
      set_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_clock_timebase.sv
// Self-checking bench for clock_timebase: directed scenarios plus random
// traffic, compared every cycle against a time-of-day reference model.
module tb_clock_timebase;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       set_req;
  logic [3:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] sec, min;
  logic       sec_tick, hr_enable, hr_reset, hr_load, set_ack, set_err;
  logic [3:0] hr_d;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: time of day as total seconds within the hour, a
  // cycle count within the current second, and the handshake phase.
  int m_phase;   // 0 = just out of reset, 1 = counting, 2 = acknowledging
  int m_tsec;
  int m_cyc;
  int m_tick, m_en, m_rst, m_load, m_d, m_ack, m_err;

  clock_timebase #(.CLKS_PER_SEC(N)) dut (
    .clk(clk), .reset(reset), .run(run), .set_req(set_req),
    .set_hour(set_hour), .set_min(set_min), .sec(sec), .min(min),
    .sec_tick(sec_tick), .hr_enable(hr_enable), .hr_reset(hr_reset),
    .hr_load(hr_load), .hr_d(hr_d), .set_ack(set_ack), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_tsec = 0; m_cyc = 0;
    m_tick = 0; m_en = 0; m_rst = 0; m_load = 0; m_d = 0;
    m_ack = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int h, mi;
    h  = int'(set_hour);
    mi = int'(set_min);
    m_tick = 0; m_en = 0; m_rst = 0; m_load = 0;
    if (reset) begin
      model_clear();
    end else if (m_phase == 0) begin
      m_en = 1; m_rst = 1; m_phase = 1;
    end else if (m_phase == 1) begin
      if (set_req) begin
        m_ack = 1; m_phase = 2;
        if (h >= 1 && h <= 12 && mi <= 59) begin
          m_tsec = mi * 60; m_cyc = 0;
          m_en = 1; m_load = 1; m_d = h; m_err = 0;
        end else begin
          m_err = 1;
        end
      end else if (run) begin
        m_cyc++;
        if (m_cyc == N) begin
          m_cyc  = 0;
          m_tick = 1;
          m_tsec = (m_tsec + 1) % 3600;
          if (m_tsec == 0) m_en = 1;
        end
      end
    end else begin
      if (!set_req) begin
        m_ack = 0; m_err = 0; m_phase = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sec"},  int'(sec), m_tsec % 60);
    check({tag, ".min"},  int'(min), m_tsec / 60);
    check({tag, ".tick"}, int'(sec_tick), m_tick);
    check({tag, ".hen"},  int'(hr_enable), m_en);
    check({tag, ".hrst"}, int'(hr_reset), m_rst);
    check({tag, ".hld"},  int'(hr_load), m_load);
    check({tag, ".hd"},   int'(hr_d), m_d);
    check({tag, ".ack"},  int'(set_ack), m_ack);
    check({tag, ".err"},  int'(set_err), m_err);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  // Handshake: hold the request for 'hold' edges, then drop it for one.
  task automatic do_set(input string tag, input int h, input int mi, input int hold);
    set_hour = 4'(h);
    set_min  = 6'(mi);
    set_req  = 1'b1;
    repeat (hold) step(tag);
    set_req = 1'b0;
    step(tag);
  endtask

  // Asynchronous reset pulse raised between edges.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_clear();
    check_all({tag, ".async"});
    step(tag);
    reset = 1'b0;
  endtask

  initial begin
    int hold_left;
    int ticks;
    bit reached;

    reset = 1'b1; run = 1'b0; set_req = 1'b0;
    set_hour = 4'd0; set_min = 6'd0;
    model_clear();
    #2 check_all("por");
    step("por");
    step("por");
    reset = 1'b0;

    // INIT pulse then idle with run=0.
    step("init");
    check("init_pulse", int'(hr_enable & hr_reset), 1);
    ticks = 0;
    repeat (8) begin
      step("idle");
      ticks += int'(sec_tick);
    end
    check("idle_ticks", ticks, 0);

    // 30 running cycles: three ticks, sec=3; then frozen.
    run = 1'b1;
    ticks = 0;
    repeat (30) begin
      step("run30");
      ticks += int'(sec_tick);
    end
    check("run30_ticks", ticks, 3);
    check("run30_sec", int'(sec), 3);
    run = 1'b0;
    ticks = 0;
    repeat (25) begin
      step("hold25");
      ticks += int'(sec_tick);
    end
    check("hold25_sec", int'(sec), 3);
    check("hold25_ticks", ticks, 0);

    // Valid set 11:59, then run across the hour.
    set_hour = 4'd11; set_min = 6'd59; set_req = 1'b1;
    step("set1159");
    check("set1159_load", int'(hr_load), 1);
    check("set1159_d", int'(hr_d), 11);
    check("set1159_ack", int'(set_ack & ~set_err), 1);
    step("set1159");
    set_req = 1'b0;
    step("set1159");
    check("set1159_ackdrop", int'(set_ack), 0);
    run = 1'b1;
    ticks = 0;
    repeat (600) begin
      step("wrap");
      ticks += int'(hr_enable & ~hr_load);
    end
    check("wrap_min", int'(min), 0);
    check("wrap_sec", int'(sec), 0);
    check("wrap_adv", ticks, 1);

    // Rejected requests: bad hours and bad minutes.
    run = 1'b0;
    do_set("bad_h0", 0, 10, 2);
    do_set("bad_h13", 13, 10, 2);
    do_set("bad_h15", 15, 10, 2);
    do_set("bad_m60", 5, 60, 2);
    do_set("bad_m63", 5, 63, 3);
    run = 1'b1;
    do_set("set_run", 12, 0, 2);

    // Request coinciding with the 59:59 -> 00:00 edge: the set wins.
    do_set("pre5959", 5, 59, 2);
    reached = 1'b0;
    for (int i = 0; i < 700 && !reached; i++) begin
      if (m_phase == 1 && m_tsec == 3599 && m_cyc == N - 1) reached = 1'b1;
      else step("to5959");
    end
    check("reach5959", int'(reached), 1);
    set_hour = 4'd7; set_min = 6'd12; set_req = 1'b1;
    step("collide");
    check("collide_load", int'(hr_load), 1);
    check("collide_min", int'(min), 12);
    check("collide_tick", int'(sec_tick), 0);
    step("collide");
    set_req = 1'b0;
    step("collide");

    // Reset while acknowledging.
    set_hour = 4'd3; set_min = 6'd3; set_req = 1'b1;
    step("ackrst");
    step("ackrst");
    do_reset("ackrst");
    set_req = 1'b0;
    step("ackrst_init");
    check("ackrst_init", int'(hr_enable & hr_reset), 1);

    // Random traffic.
    hold_left = 0;
    for (int c = 0; c < 4000; c++) begin
      run = ($urandom_range(0, 9) != 0);
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) set_req = 1'b0;
      end else if ($urandom_range(0, 60) == 0) begin
        set_hour  = 4'($urandom_range(0, 15));
        set_min   = 6'($urandom_range(0, 63));
        set_req   = 1'b1;
        hold_left = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 999) == 0) do_reset("rnd_rst");
      else step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_timebase.md
# clock_timebase

Upstream driver for the 1–12 hour counter in the clock datapath. Divides the system clock down to a 1 s tick and maintains seconds and minutes counters (0–59 each). Produces the hour counter's control strobes: a one-cycle advance pulse on every minute wrap, a one-cycle reset pulse after system reset, and a one-cycle load pulse when the user sets the time through a req/ack handshake.

## Interface
- CLKS_PER_SEC, default 10, clk cycles per second tick. Legal values are ≥2; small for simulation, set to board frequency at top level.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; all state is cleared while high
- run  in  1  1 = timekeeping advances; 0 = prescaler, sec and min frozen
- set_req  in  1  set-time request, level; held until set_ack seen
- set_hour  in  4  requested hour, legal 1..12
- set_min  in  6  requested minute, legal 0..59
- sec  out  6  current seconds, 0..59
- min  out  6  current minutes, 0..59
- sec_tick  out  1  one-cycle pulse per second boundary
- hr_enable  out  1  to hour counter enable
- hr_reset  out  1  to hour counter reset
- hr_load  out  1  to hour counter load
- hr_d  out  4  to hour counter load data
- set_ack  out  1  handshake acknowledge
- set_err  out  1  valid with set_ack; 1 = request rejected

## Operation
- All outputs are registered. The block has one clock. Reset is asynchronous and active-high.
- Reset values: sec=0, min=0, prescaler=0, sec_tick=0, hr_enable=0, hr_reset=0, hr_load=0, hr_d=0, set_ack=0, set_err=0, state=INIT.
- FSM states: INIT, COUNT, ACK.
- INIT: at the first edge after reset release, set hr_enable=1 and hr_reset=1 for exactly one cycle, then go to COUNT. The hour counter returns to 1 at its next edge. set_req is ignored in INIT.
- COUNT, no set_req, run=1:
  - Prescaler counts 0..CLKS_PER_SEC-1, then wraps to 0.
  - On the wrap edge: sec_tick<=1 and sec increments.
  - sec 59→0 increments min.
  - min 59→0 (at sec 59→0) sets hr_enable<=1 with hr_load=0 and hr_reset=0, for one cycle.
- COUNT, run=0: prescaler, sec and min hold. No ticks. Set is still accepted.
- COUNT, set_req=1 sampled at an edge:
  - If valid (set_hour in 1..12 and set_min ≤59):
    - min<=set_min, sec<=0, prescaler<=0.
    - hr_enable<=1, hr_load<=1, hr_d<=set_hour, for one cycle.
    - set_ack<=1, set_err<=0, then go to ACK.
  - If invalid: sec, min, prescaler and hour controls are unchanged. set_ack<=1, set_err<=1, then go to ACK.
- ACK: counting frozen, set_ack and set_err held. When set_req=0 is sampled: set_ack<=0, set_err<=0, go to COUNT. Counting resumes the next cycle.
- hr_d holds its last loaded value. It is meaningful only while hr_load=1.
- Width rules:
  - Prescaler width is $clog2(CLKS_PER_SEC).
  - sec and min compare against 59 exactly, and never exceed 59.
  - set_hour and set_min validity is checked on the full input width.

## Timing
- Second tick: with run=1 held, sec_tick pulses every CLKS_PER_SEC cycles. The sec update is visible in the same cycle as the sec_tick pulse.
- Minute wrap: hr_enable is high during the cycle in which min:sec first reads 00:00. The hour counter advances on the following edge.
- Set latency: one edge from sampled set_req to set_ack=1. min, sec and the hr_load pulse appear in that same cycle.
- Minimum handshake length: 2 cycles. A new request is only accepted in COUNT.
- Simultaneous events:
  - set_req accepted on the same edge as a prescaler wrap: the set wins. The tick and any hour advance are discarded.
  - run=0 while set_req=1: the set proceeds normally.
- Reset mid-handshake or mid-pulse: all outputs clear immediately (asynchronously), then the INIT sequence re-runs.

## Test plan
- Reset release with CLKS_PER_SEC=10 and run=0 → exactly one cycle of hr_enable=hr_reset=1 on the first edge; sec=min=0; no sec_tick afterwards.
- run=1 for 30 cycles → sec_tick on cycles 10, 20, 30 and sec=3; deassert run for 25 cycles → sec stays 3 with no ticks.
- Set 11:59 (valid), then run past 60 seconds → set_ack=1 with set_err=0; one cycle of hr_load=1 with hr_d=11; after 600 cycles min=0, sec=0 and a single hr_enable pulse with hr_load=0.
- Set hour 0, then hour 13, then min 60 → each gives set_ack=1 with set_err=1; sec and min unchanged; no hr_* pulse; set_ack drops the cycle after set_req drops.
- Assert set_req on the edge where sec goes 59→0 at min 59 → set applied; no hr_enable-only advance pulse; min=set_min, sec=0.
- Assert reset while in ACK → set_ack, set_err and all hr_* outputs are 0 immediately; the INIT pulse follows release.
